// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM responder model.
// Holds the bus-state enum, bus widths and an address range helper.
package sram_responder_pkg;

  localparam int DQ_WIDTH   = 16;
  localparam int ADDR_WIDTH = 18;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } bus_state_e;

  // True when any address bit at or above the modeled depth is set.
  function automatic logic addr_hi_nz(
    input logic [ADDR_WIDTH-1:0] a,
    input int                    lo
  );
    return (a >> lo) != '0;
  endfunction

endpackage

// File: rtl/sram_responder_rd_pipe.sv
// READ_LATENCY-deep {valid, addr} shift pipeline for accepted reads.
// Ports: clk, rst (async active-low), push/push_addr in, out_valid/out_addr.
module sram_responder_rd_pipe #(
  parameter int LAT = 1,
  parameter int AW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [LAT-1:0] vld;
  logic [AW-1:0]  adr [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Address lanes carry no reset; only valid bits qualify them.
  always_ff @(posedge clk) begin
    adr[0] <= push_addr;
    for (int i = 1; i < LAT; i++) begin
      adr[i] <= adr[i-1];
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_addr  = adr[LAT-1];

endmodule

// File: rtl/sram_responder.sv
// Behavioral async-SRAM responder: byte-lane writes, pipelined reads.
// Ports: clk, rst (async active-low), sram_dq_io (inout 16b),
// sram_addr_in (18b), active-low ub/lb/we/ce/oe strobes,
// rd_valid_out, protocol_err_out. Optional bus checks under
// macro SRAM_RESPONDER_BUS_CHECK_EN.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] sram_dq_io,
  input  logic [17:0] sram_addr_in,
  input  logic        sram_ub_n_in,
  input  logic        sram_lb_n_in,
  input  logic        sram_we_n_in,
  input  logic        sram_ce_n_in,
  input  logic        sram_oe_n_in,
  output logic        rd_valid_out,
  output logic        protocol_err_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DQ_WIDTH-1:0]   mem [DEPTH];
  logic [DQ_WIDTH-1:0]   rd_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  cls_wr;
  logic                  cls_rd;
  logic                  pipe_valid;
  logic [DEPTH_LOG2-1:0] pipe_addr;
  logic                  drv;
  bus_state_e            state;

  assign idx    = sram_addr_in[DEPTH_LOG2-1:0];
  assign cls_wr = !sram_ce_n_in && !sram_we_n_in;
  assign cls_rd = !sram_ce_n_in && sram_we_n_in
                  && !sram_oe_n_in;

  always_ff @(posedge clk) begin
    if (cls_wr) begin
      if (!sram_lb_n_in) mem[idx][7:0]  <= sram_dq_io[7:0];
      if (!sram_ub_n_in) mem[idx][15:8] <= sram_dq_io[15:8];
    end
  end

  sram_responder_rd_pipe #(
    .LAT (READ_LATENCY),
    .AW  (DEPTH_LOG2)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (cls_rd),
    .push_addr (idx),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  // Storage is read at pipeline exit so in-flight writes are seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_out <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_valid_out <= pipe_valid;
      if (pipe_valid) rd_data <= mem[pipe_addr];
    end
  end

  // Live strobes gate the drive so a write releases the bus at once.
  assign drv = rd_valid_out && cls_rd;

  assign sram_dq_io[7:0] =
    (drv && !sram_lb_n_in) ? rd_data[7:0] : 8'hzz;
  assign sram_dq_io[15:8] =
    (drv && !sram_ub_n_in) ? rd_data[15:8] : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (1'b1)
        cls_wr:  state <= WR;
        cls_rd:  state <= RD;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_RESPONDER_BUS_CHECK_EN
  logic prev_oe_n;
  logic err_hit;

  assign err_hit =
    (cls_wr && sram_ub_n_in && sram_lb_n_in)
    || ((cls_wr || cls_rd)
        && addr_hi_nz(sram_addr_in, DEPTH_LOG2))
    || (cls_rd && state == WR && !prev_oe_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_oe_n        <= 1'b1;
      protocol_err_out <= 1'b0;
    end else begin
      prev_oe_n <= sram_oe_n_in;
      if (err_hit) protocol_err_out <= 1'b1;
    end
  end
`else
  logic unused_chk;

  assign protocol_err_out = 1'b0;
  assign unused_chk = ^{state, sram_addr_in};
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (READ_LATENCY=3).
// Vector table plus scoreboard of expected read words.
module tb_sram_responder;

  localparam int LAT = 3;
`ifdef SRAM_RESPONDER_BUS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n, drv;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [15:0] exp;
    logic        seterr;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] addr = '0;
  logic        ub_n = 1'b1, lb_n = 1'b1;
  logic        we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] dq;
  logic        rd_valid_out;
  logic        protocol_err_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic exp_err = 1'b0;
  vec_t cur;
  sb_t  sb[$];
  vec_t tbl[$];

  assign dq = tb_drv ? tb_dq : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
  end

  sram_responder #(
    .DEPTH_LOG2   (10),
    .READ_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst_n),
    .sram_dq_io       (dq),
    .sram_addr_in     (addr),
    .sram_ub_n_in     (ub_n),
    .sram_lb_n_in     (lb_n),
    .sram_we_n_in     (we_n),
    .sram_ce_n_in     (ce_n),
    .sram_oe_n_in     (oe_n),
    .rd_valid_out     (rd_valid_out),
    .protocol_err_out (protocol_err_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic ce, we, oe, ub, lb, d,
    input logic [17:0] a,
    input logic [15:0] wd, ex,
    input logic se
  );
    vec_t v;
    v.ce_n = ce; v.we_n = we; v.oe_n = oe;
    v.ub_n = ub; v.lb_n = lb; v.drv = d;
    v.addr = a; v.dq = wd; v.exp = ex;
    v.seterr = se;
    return v;
  endfunction

  function automatic vec_t W(input logic [17:0] a,
                             input logic [15:0] d);
    return mk(0, 0, 1, 0, 0, 1, a, d, 0, 0);
  endfunction

  function automatic vec_t R(input logic [17:0] a,
                             input logic [15:0] e);
    return mk(0, 1, 0, 0, 0, 0, a, 0, e, 0);
  endfunction

  function automatic vec_t I();
    return mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, req);
    end
  endtask

  task automatic check_cycle();
    logic        ev;
    logic [15:0] ed, edq;
    ev = 1'b0;
    ed = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      ev = 1'b1;
      ed = sb[0].d;
      void'(sb.pop_front());
    end
    edq = 16'hFFFF;
    if (cur.drv) begin
      edq = cur.dq;
    end else if (ev && !cur.ce_n && cur.we_n && !cur.oe_n) begin
      if (!cur.lb_n) edq[7:0]  = ed[7:0];
      if (!cur.ub_n) edq[15:8] = ed[15:8];
    end
    chk("rd_valid", {15'b0, rd_valid_out}, {15'b0, ev});
    chk("dq", dq, edq);
    chk("protocol_err", {15'b0, protocol_err_out},
        {15'b0, exp_err});
  endtask

  task automatic drive(input vec_t v);
    cur  = v;
    ce_n = v.ce_n; we_n = v.we_n; oe_n = v.oe_n;
    ub_n = v.ub_n; lb_n = v.lb_n;
    addr = v.addr; tb_dq = v.dq; tb_drv = v.drv;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk);
    cyc++;
    if (!v.ce_n && v.we_n && !v.oe_n)
      sb.push_back('{due: cyc + LAT, d: v.exp});
    if (v.seterr) exp_err = CHK;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    drive(I());
    rst_n = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    #1;
    chk("rst_async_valid", {15'b0, rd_valid_out}, 16'h0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) apply(I());
  endtask

  initial begin
    cur = I();
    @(negedge clk);
    do_reset();

    tbl.push_back(W(5, 16'hBEEF));
    for (int i = 0; i < 4; i++) tbl.push_back(R(5, 16'hBEEF));
    for (int i = 0; i < 3; i++) tbl.push_back(I());
    tbl.push_back(W(9, 16'h1234));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 9, 16'hABCD, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(R(9, 16'hAB34));
    for (int i = 0; i < 3; i++) tbl.push_back(I());
    tbl.push_back(W(0, 16'h0000));
    tbl.push_back(W(1, 16'h0011));
    tbl.push_back(W(2, 16'h0022));
    tbl.push_back(W(3, 16'h0033));
    tbl.push_back(R(0, 16'h0000));
    tbl.push_back(R(1, 16'h0011));
    tbl.push_back(R(2, 16'h0022));
    for (int i = 0; i < 4; i++) tbl.push_back(R(3, 16'h0033));
    for (int i = 0; i < 3; i++) tbl.push_back(I());
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 5, 0, 16'hBEEF, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(I());
    foreach (tbl[k]) apply(tbl[k]);

    // A write landing while a read is in flight is returned.
    apply(R(5, 16'h5A5A));
    apply(W(5, 16'h5A5A));
    for (int i = 0; i < 3; i++) apply(R(5, 16'h5A5A));
    idles(3);

    // Write strobes release the bus, even with data pending.
    apply(R(9, 16'hAB34));
    apply(W(50, 16'h1357));
    apply(I());
    apply(mk(0, 0, 1, 0, 0, 0, 100, 0, 0, 0));
    idles(2);

    // Reset mid-read: nothing surfaces until a new read finishes.
    apply(R(9, 16'hAB34));
    apply(I());
    do_reset();
    for (int i = 0; i < 4; i++) apply(R(9, 16'hAB34));
    idles(3);

    // Out-of-range address aliases and flags when checks exist.
    do_reset();
    apply(mk(0, 0, 1, 0, 0, 1, 18'h00400, 16'h7777, 0, 1));
    apply(I());
    for (int i = 0; i < 4; i++) apply(R(0, 16'h7777));
    idles(3);

    do_reset();
    apply(mk(0, 0, 0, 0, 0, 1, 11, 16'h2468, 0, 0));
    apply(mk(0, 1, 0, 0, 0, 0, 11, 0, 16'h2468, 1));
    for (int i = 0; i < 3; i++) apply(R(11, 16'h2468));
    idles(3);

    do_reset();
    apply(mk(0, 0, 1, 1, 1, 1, 12, 16'h1111, 0, 1));
    idles(2);
    do_reset();
    idles(1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
